// File: rtl/pcs_pkg.sv
// Shared definitions for the pulse counter scheduler: FSM encoding and default sizing.
package pcs_pkg;

    localparam int DEF_NREQ = 4;
    localparam int DEF_LENW = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BURST = 2'd1,
        GAP   = 2'd2
    } state_t;

endpackage

// File: rtl/pulse_counter_scheduler_rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or after ptr, wrapping modulo NREQ.
module rr_arbiter #(
    parameter  int NREQ = 4,
    localparam int IDXW = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDXW-1:0] ptr,
    output logic [NREQ-1:0] sel,
    output logic [IDXW-1:0] idx,
    output logic            any
);

    always_comb begin
        int j;
        any = 1'b0;
        idx = '0;
        sel = '0;
        j   = 0;
        for (int i = 0; i < NREQ; i++) begin
            j = int'(ptr) + i;
            if (j >= NREQ) j = j - NREQ;
            if (!any && req[j]) begin
                any = 1'b1;
                idx = IDXW'(j);
            end
        end
        if (any) sel[idx] = 1'b1;
    end

endmodule

// File: rtl/pulse_counter_scheduler.sv
// Round-robin owner of a two-cycle-qualified counter: 2*len inc cycles per grant, then a gap cycle with done.
module pulse_counter_scheduler
    import pcs_pkg::*;
#(
    parameter  int NREQ = DEF_NREQ,
    parameter  int LENW = DEF_LENW,
    localparam int IDXW = $clog2(NREQ)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ*LENW-1:0] len,
    output logic [NREQ-1:0]      gnt,
    output logic [NREQ-1:0]      done,
    output logic                 inc,
    output logic                 busy,
    output logic [IDXW-1:0]      owner
);

    localparam logic [LENW:0] REM_ONE = (LENW+1)'(1);

    state_t          state_q, state_d;
    logic [LENW:0]   rem_q, rem_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic [NREQ-1:0] done_q, done_d;
    logic            inc_q, inc_d;
    logic            busy_q, busy_d;
    logic [IDXW-1:0] owner_q, owner_d;
    logic [IDXW-1:0] ptr_q, ptr_d;

    logic [NREQ-1:0] arb_sel;
    logic [IDXW-1:0] arb_idx;
    logic            arb_any;
    logic [LENW-1:0] sel_len;

    rr_arbiter #(.NREQ(NREQ)) u_arb (
        .req (req),
        .ptr (ptr_q),
        .sel (arb_sel),
        .idx (arb_idx),
        .any (arb_any)
    );

    assign sel_len = len[int'(arb_idx)*LENW +: LENW];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (arb_any) state_d = (sel_len != '0) ? BURST : GAP;
            BURST:   if (rem_q == REM_ONE) state_d = GAP;
            GAP:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // All outputs are computed one cycle ahead so they leave the block straight from flops.
    always_comb begin
        rem_d   = rem_q;
        gnt_d   = gnt_q;
        done_d  = '0;
        inc_d   = 1'b0;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        case (state_q)
            IDLE: begin
                if (arb_any) begin
                    rem_d   = {sel_len, 1'b0};
                    gnt_d   = arb_sel;
                    owner_d = arb_idx;
                    inc_d   = (sel_len != '0);
                    done_d  = (sel_len == '0) ? arb_sel : '0;
                end
            end
            BURST: begin
                rem_d = rem_q - REM_ONE;
                inc_d = (rem_q != REM_ONE);
                if (rem_q == REM_ONE) done_d = gnt_q;
            end
            GAP: begin
                gnt_d = '0;
                ptr_d = (owner_q == IDXW'(NREQ-1)) ? '0 : owner_q + IDXW'(1);
            end
            default: gnt_d = '0;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rem_q   <= '0;
            gnt_q   <= '0;
            done_q  <= '0;
            inc_q   <= 1'b0;
            busy_q  <= 1'b0;
            owner_q <= '0;
            ptr_q   <= '0;
        end else begin
            rem_q   <= rem_d;
            gnt_q   <= gnt_d;
            done_q  <= done_d;
            inc_q   <= inc_d;
            busy_q  <= busy_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
        end
    end

    assign gnt   = gnt_q;
    assign done  = done_q;
    assign inc   = inc_q;
    assign busy  = busy_q;
    assign owner = owner_q;

endmodule
